// File: rtl/mul_seq_ctrl_pkg.sv
// Shared widths and FSM state encoding for the sequential multiplier.
// Widths are tied to the single shared 32-bit adder and are not meant to be changed.
package mul_seq_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        MS_IDLE   = 3'd0,
        MS_FIX_A  = 3'd1,
        MS_FIX_B  = 3'd2,
        MS_ITER   = 3'd3,
        MS_FIX_LO = 3'd4,
        MS_FIX_HI = 3'd5,
        MS_DONE   = 3'd6
    } ms_state_t;

endpackage

// File: rtl/mul_seq_ctrl_add.sv
// 32-bit ripple adder with carry-out, shared by every multiplier step; purely combinational.
// No flow control: operands are driven every cycle by the owning FSM.
module mul_seq_ctrl_add
    import mul_seq_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s,
    output logic              c
);

    assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add 32x32->64 multiplier (MULT/MULTU); done 33 cycles after start (unsigned), 37 (signed).
// busy holds the pipeline while not IDLE; start is ignored while busy, flush aborts to IDLE.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_signed,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    ms_state_t               state, state_nxt;
    logic [2*DATA_W-1:0]     p, p_nxt;
    logic [DATA_W-1:0]       m, m_nxt;
    logic [CNT_W-1:0]        count;
    logic                    sgn, cy, cy_nxt, op_sgn;
    logic                    accept;
    logic [DATA_W-1:0]       add_a, add_b, add_s;
    logic                    add_c;

    mul_seq_ctrl_add u_add (
        .a (add_a),
        .b (add_b),
        .s (add_s),
        .c (add_c)
    );

    assign accept = (state == MS_IDLE) && start && !flush;

    // Adder operands depend on state alone; negation is ~x + 1 through the same adder.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            MS_FIX_A:  begin add_a = ~p[DATA_W-1:0];        add_b = DATA_W'(1); end
            MS_FIX_B:  begin add_a = ~m;                    add_b = DATA_W'(1); end
            MS_ITER:   begin add_a = p[2*DATA_W-1:DATA_W];  add_b = m;          end
            MS_FIX_LO: begin add_a = ~p[DATA_W-1:0];        add_b = DATA_W'(1); end
            MS_FIX_HI: begin add_a = ~p[2*DATA_W-1:DATA_W]; add_b = {{(DATA_W-1){1'b0}}, cy}; end
            default:   begin add_a = '0;                    add_b = '0;         end
        endcase
    end

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        m_nxt     = m;
        cy_nxt    = cy;
        case (state)
            MS_IDLE: begin
                if (start) begin
                    p_nxt     = {{DATA_W{1'b0}}, a};
                    m_nxt     = b;
                    state_nxt = op_signed ? MS_FIX_A : MS_ITER;
                end
            end
            MS_FIX_A: begin
                // P still holds the raw multiplicand, so P[31] is its sign.
                if (p[DATA_W-1]) p_nxt[DATA_W-1:0] = add_s;
                state_nxt = MS_FIX_B;
            end
            MS_FIX_B: begin
                if (m[DATA_W-1]) m_nxt = add_s;
                state_nxt = MS_ITER;
            end
            MS_ITER: begin
                if (p[0]) p_nxt = {add_c, add_s, p[DATA_W-1:1]};
                else      p_nxt = {1'b0, p[2*DATA_W-1:1]};
                if (count == CNT_W'(DATA_W - 1))
                    state_nxt = op_sgn ? MS_FIX_LO : MS_DONE;
            end
            MS_FIX_LO: begin
                if (sgn) begin
                    p_nxt[DATA_W-1:0] = add_s;
                    cy_nxt            = add_c;
                end else begin
                    cy_nxt = 1'b0;
                end
                state_nxt = MS_FIX_HI;
            end
            MS_FIX_HI: begin
                if (sgn) p_nxt[2*DATA_W-1:DATA_W] = add_s;
                state_nxt = MS_DONE;
            end
            MS_DONE:  state_nxt = MS_IDLE;
            default:  state_nxt = MS_IDLE;
        endcase
        if (flush) state_nxt = MS_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MS_IDLE;
            p      <= '0;
            m      <= '0;
            count  <= '0;
            sgn    <= 1'b0;
            op_sgn <= 1'b0;
            cy     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            cy    <= cy_nxt;
            busy  <= (state_nxt != MS_IDLE);
            done  <= (state_nxt == MS_DONE);
            if (accept) begin
                p      <= p_nxt;
                m      <= m_nxt;
                count  <= '0;
                op_sgn <= op_signed;
                sgn    <= op_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
            end else if (state != MS_IDLE) begin
                p <= p_nxt;
                m <= m_nxt;
                if (state == MS_ITER) count <= count + CNT_W'(1);
            end
            // Results land on the edge that enters DONE, from the final P value.
            if (state_nxt == MS_DONE && state != MS_DONE) begin
                hi <= p_nxt[2*DATA_W-1:DATA_W];
                lo <= p_nxt[DATA_W-1:0];
            end
        end
    end

endmodule
